// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel-side handshake bundle of the UART transmitter.
//   tx_start     request to send din (master -> transmitter)
//   din          byte to send (master -> transmitter)
//   tx           serial line, idle high (transmitter -> pin)
//   busy         frame in progress (transmitter -> master)
//   tx_done_tick one-clock pulse at frame end (transmitter -> master)
// Modports: master = interface/FIFO side, slave = uart_tx.
interface uart_tx_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx;
  logic            busy;
  logic            tx_done_tick;

  modport master (
    output tx_start,
    output din,
    input  tx,
    input  busy,
    input  tx_done_tick
  );

  modport slave (
    input  tx_start,
    input  din,
    output tx,
    output busy,
    output tx_done_tick
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter driven by an oversampling baud tick.
// Shifts a latched byte out LSB-first as an 8N1 frame, or 8E1 when the
// compile-time macro UART_TX_PARITY_EN is defined (one even-parity bit
// between the last data bit and the stop bit).
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active high; aborts any frame in flight
//   tick  baud tick, 1 clk wide, OVERSAMPLE ticks per bit (may be stuck high)
//   bus   uart_tx_if.slave: tx_start/din in, tx/busy/tx_done_tick out
// Parameters: DBIT data bits, OVERSAMPLE ticks per start/data/parity bit,
//   SB_TICK ticks for the stop period.
module uart_tx #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  uart_tx_if.slave   bus
);

  localparam int SMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity bit: makes the total count of ones in data+parity even.
  function automatic logic even_parity(input logic [DBIT-1:0] d);
    return ^d;
  endfunction

  logic            parity_r;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t          state_r;
  logic [SW-1:0]   s_r;
  logic [NW-1:0]   n_r;
  logic [DBIT-1:0] shreg_r;
  logic            tx_r;
  logic            busy_r;
  logic            done_r;
  logic [DBIT-1:0] shreg_shift_s;

  // Shift register contents after dropping the bit currently on the line.
  assign shreg_shift_s = {1'b0, shreg_r[DBIT-1:1]};

  // Frame sequencer. tx is loaded with the level of the state being entered,
  // so the line changes on the same edge as the state and never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      s_r      <= '0;
      n_r      <= '0;
      shreg_r  <= '0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          if (bus.tx_start) begin
            shreg_r  <= bus.din;
            s_r      <= '0;
            n_r      <= '0;
            tx_r     <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= START;
`ifdef UART_TX_PARITY_EN
            parity_r <= even_parity(bus.din);
`endif
          end
        end
        START: begin
          if (tick) begin
            if (s_r == S_BIT_LAST) begin
              s_r     <= '0;
              n_r     <= '0;
              tx_r    <= shreg_r[0];
              state_r <= DATA;
            end else begin
              s_r <= s_r + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_r == S_BIT_LAST) begin
              s_r     <= '0;
              shreg_r <= shreg_shift_s;
              if (n_r == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                tx_r    <= parity_r;
                state_r <= PARITY;
`else
                tx_r    <= 1'b1;
                state_r <= STOP;
`endif
              end else begin
                n_r  <= n_r + NW'(1);
                tx_r <= shreg_shift_s[0];
              end
            end else begin
              s_r <= s_r + SW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s_r == S_BIT_LAST) begin
              s_r     <= '0;
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              s_r <= s_r + SW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (s_r == S_STOP_LAST) begin
              s_r     <= '0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= IDLE;
            end else begin
              s_r <= s_r + SW'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          s_r     <= '0;
          n_r     <= '0;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx           = tx_r;
  assign bus.busy         = busy_r;
  assign bus.tx_done_tick = done_r;

endmodule
